// File: rtl/wbuf_coalesce_pkg.sv
// Shared constants and helpers for the coalescing write buffer.
package wbuf_coalesce_pkg;

  localparam int BYTE_W = 8;

  // Wrapping pointer increment shared by the head and tail pointers.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
    return (p + 32'd1) % depth;
  endfunction

endpackage

// File: rtl/wbuf_match.sv
// Youngest-match priority select over a circular buffer ordered from hd.
// Valid entries are contiguous from hd, so the last match seen while
// walking forward from hd is the youngest one.
module wbuf_match
  import wbuf_coalesce_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic [PW-1:0]    hd,
  input  logic [DEPTH-1:0] eq,
  output logic [DEPTH-1:0] sel,
  output logic             hit
);

  logic [PW-1:0] idx_s;

  // Walk the ring oldest to youngest; every later match overrides the earlier one.
  always_comb begin
    sel   = '0;
    hit   = 1'b0;
    idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = hd + PW'(i);
      if (eq[idx_s]) begin
        sel        = '0;
        sel[idx_s] = 1'b1;
        hit        = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/wbuf_coalesce.sv
// Parametrised store write buffer: in-order drain to memory, byte-lane
// coalescing into the youngest entry, and a load forwarding lookup.
module wbuf_coalesce #(
  parameter int DEPTH    = 4,
  parameter int AW       = 27,
  parameter int DW       = 32,
  parameter int COALESCE = 1
) (
  input  logic                   ph1,
  input  logic                   reset,
  input  logic                   en,
  input  logic [AW-1:0]          adr,
  input  logic [DW-1:0]          data,
  input  logic [DW/8-1:0]        byteen,
  output logic                   done,
  input  logic [AW-1:0]          lkadr,
  input  logic [DW/8-1:0]        lkbyteen,
  output logic                   lkhit,
  output logic                   lkcover,
  output logic [DW-1:0]          lkdata,
  output logic [AW-1:0]          memadr,
  output logic [DW-1:0]          memdata,
  output logic [DW/8-1:0]        membyteen,
  output logic                   memen,
  input  logic                   memdone,
  input  logic                   flush,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  import wbuf_coalesce_pkg::*;

  localparam int BE      = DW / 8;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam bit COAL_EN = (COALESCE != 0);

  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0]    adr_r  [DEPTH];
  logic [DW-1:0]    data_r [DEPTH];
  logic [BE-1:0]    be_r   [DEPTH];
  logic [PW-1:0]    hd_r;
  logic [PW-1:0]    tl_r;
  logic [CW-1:0]    count_r;

  logic [PW-1:0]    y_s;
  logic             coal_s;
  logic             push_s;
  logic             merge_s;
  logic             retire_s;
  logic [DEPTH-1:0] eq_s;
  logic [DEPTH-1:0] sel_s;
  logic             hit_s;
  logic [BE-1:0]    lkbe_s;

  // Store acceptance: merge into the youngest entry when it is not the head
  // (the head may be mid-write), otherwise allocate a new slot if one is free.
  always_comb begin
    y_s      = tl_r - PW'(1);
    coal_s   = COAL_EN & valid_r[y_s] & (y_s != hd_r) & (adr_r[y_s] == adr);
    done     = ~flush & (coal_s | (count_r < CW'(DEPTH)));
    push_s   = en & done & ~coal_s;
    merge_s  = en & done & coal_s;
    retire_s = valid_r[hd_r] & memdone;
  end

  // Memory side presents the head entry directly so it stays stable until retired.
  always_comb begin
    memen     = valid_r[hd_r];
    memadr    = adr_r[hd_r];
    memdata   = data_r[hd_r];
    membyteen = be_r[hd_r];
    count     = count_r;
    empty     = (count_r == CW'(0));
  end

  // Per-entry address compare for the load lookup.
  always_comb begin
    eq_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eq_s[i] = valid_r[i] & (adr_r[i] == lkadr);
    end
  end

  wbuf_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .hd  (hd_r),
    .eq  (eq_s),
    .sel (sel_s),
    .hit (hit_s)
  );

  // And-or mux of the one-hot youngest match onto the lookup outputs.
  always_comb begin
    lkdata = '0;
    lkbe_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lkdata = lkdata | (data_r[i] & {DW{sel_s[i]}});
      lkbe_s = lkbe_s | (be_r[i] & {BE{sel_s[i]}});
    end
    lkhit   = hit_s;
    lkcover = hit_s & ((lkbe_s & lkbyteen) == lkbyteen);
  end

  // Buffer state: allocate at tail, merge into youngest, retire at head.
  always_ff @(posedge ph1) begin
    if (reset) begin
      valid_r <= '0;
      hd_r    <= '0;
      tl_r    <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_r[i]  <= '0;
        data_r[i] <= '0;
        be_r[i]   <= '0;
      end
    end else begin
      if (push_s) begin
        adr_r[tl_r]   <= adr;
        data_r[tl_r]  <= data;
        be_r[tl_r]    <= byteen;
        valid_r[tl_r] <= 1'b1;
        tl_r          <= PW'(ptr_inc(32'(tl_r), 32'(DEPTH)));
      end
      if (merge_s) begin
        for (int b = 0; b < BE; b++) begin
          if (byteen[b]) begin
            data_r[y_s][b*BYTE_W +: BYTE_W] <= data[b*BYTE_W +: BYTE_W];
          end
        end
        be_r[y_s] <= be_r[y_s] | byteen;
      end
      if (retire_s) begin
        valid_r[hd_r] <= 1'b0;
        hd_r          <= PW'(ptr_inc(32'(hd_r), 32'(DEPTH)));
      end
      case ({push_s, retire_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_wbuf_coalesce.sv
// Self-checking bench for wbuf_coalesce against a queue-based reference model.
module tb_wbuf_coalesce;

  localparam int DEPTH = 4;
  localparam int AW    = 27;
  localparam int DW    = 32;
  localparam int BE    = 4;
  localparam int CW    = 3;

  logic          ph1 = 1'b0;
  logic          reset, en, done, lkhit, lkcover, memen, memdone, flush, empty;
  logic [AW-1:0] adr, lkadr, memadr;
  logic [DW-1:0] data, lkdata, memdata;
  logic [BE-1:0] byteen, lkbyteen, membyteen;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BE-1:0] b;
  } ent_t;

  ent_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  wbuf_coalesce #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .COALESCE(1)) dut (
    .ph1       (ph1),
    .reset     (reset),
    .en        (en),
    .adr       (adr),
    .data      (data),
    .byteen    (byteen),
    .done      (done),
    .lkadr     (lkadr),
    .lkbyteen  (lkbyteen),
    .lkhit     (lkhit),
    .lkcover   (lkcover),
    .lkdata    (lkdata),
    .memadr    (memadr),
    .memdata   (memdata),
    .membyteen (membyteen),
    .memen     (memen),
    .memdone   (memdone),
    .flush     (flush),
    .empty     (empty),
    .count     (count)
  );

  always #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs against the model, clock, then advance the model.
  task automatic step();
    logic          coal, edone, hit, cov;
    logic [DW-1:0] ld;
    logic [BE-1:0] lb;
    ent_t          e;
    int            pre;
    #1;
    coal  = (q.size() >= 2) && (q[q.size()-1].a == adr);
    edone = !flush && (coal || (q.size() < DEPTH));
    chk("done",  64'(done),  64'(edone));
    chk("memen", 64'(memen), 64'(q.size() > 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    if (q.size() > 0) begin
      chk("memadr",    64'(memadr),    64'(q[0].a));
      chk("memdata",   64'(memdata),   64'(q[0].d));
      chk("membyteen", 64'(membyteen), 64'(q[0].b));
    end
    hit = 1'b0;
    ld  = '0;
    lb  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && (q[i].a == lkadr)) begin
        hit = 1'b1;
        ld  = q[i].d;
        lb  = q[i].b;
      end
    end
    cov = hit && ((lb & lkbyteen) == lkbyteen);
    chk("lkhit",   64'(lkhit),   64'(hit));
    chk("lkcover", 64'(lkcover), 64'(cov));
    if (hit) chk("lkdata", 64'(lkdata), 64'(ld));
    @(posedge ph1);
    pre = q.size();
    if (reset) begin
      q.delete();
    end else begin
      if (en && edone) begin
        if (coal) begin
          e = q[q.size()-1];
          for (int k = 0; k < BE; k++) begin
            if (byteen[k]) e.d[8*k +: 8] = data[8*k +: 8];
          end
          e.b = e.b | byteen;
          q[q.size()-1] = e;
        end else begin
          e.a = adr;
          e.d = data;
          e.b = byteen;
          q.push_back(e);
        end
      end
      if (memdone && (pre > 0)) e = q.pop_front();
    end
    @(negedge ph1);
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE-1:0] b);
    en     = 1'b1;
    adr    = a;
    data   = d;
    byteen = b;
    step();
    en     = 1'b0;
  endtask

  task automatic drain();
    en      = 1'b0;
    memdone = 1'b1;
    repeat (DEPTH + 1) step();
    memdone = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; adr = '0; data = '0; byteen = '0;
    lkadr = '0; lkbyteen = '0; memdone = 1'b0; flush = 1'b0;
    @(posedge ph1);
    @(negedge ph1);
    reset = 1'b0;
    #1;
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_memen",   64'(memen),   64'd0);
    chk("rst_empty",   64'(empty),   64'd1);
    chk("rst_lkhit",   64'(lkhit),   64'd0);
    chk("rst_lkcover", 64'(lkcover), 64'd0);

    // Single store then retire.
    st(27'h10, 32'hAABBCCDD, 4'b1111);
    chk("t1_count",   64'(count),   64'd1);
    chk("t1_memen",   64'(memen),   64'd1);
    chk("t1_memadr",  64'(memadr),  64'h10);
    chk("t1_memdata", 64'(memdata), 64'hAABBCCDD);
    memdone = 1'b1;
    step();
    memdone = 1'b0;
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_memen_off", 64'(memen), 64'd0);

    // Coalescing into the youngest (non-head) entry.
    st(27'h10, 32'h01020304, 4'b1111);
    st(27'h20, 32'h00000011, 4'b0001);
    st(27'h20, 32'h00330000, 4'b0100);
    chk("t2_count",  64'(count),  64'd2);
    chk("t2_memadr", 64'(memadr), 64'h10);
    lkadr = 27'h20; lkbyteen = 4'b0101;
    #1;
    chk("t2_lkhit",   64'(lkhit),   64'd1);
    chk("t2_lkcover", 64'(lkcover), 64'd1);
    chk("t2_lkdata",  64'(lkdata),  64'h00330011);
    drain();

    // Head never coalesces; full buffer back-pressure; accept after retire.
    st(27'h10, 32'h1, 4'b1111);
    st(27'h10, 32'h2, 4'b1111);
    chk("t3_count2", 64'(count), 64'd2);
    st(27'h40, 32'h40, 4'b1111);
    st(27'h41, 32'h41, 4'b1111);
    en = 1'b1; adr = 27'h42; data = 32'h42; byteen = 4'b1111;
    step();
    chk("t3_full_done", 64'(done), 64'd0);
    memdone = 1'b1;
    step();
    memdone = 1'b0;
    chk("t3_after_retire_done", 64'(done), 64'd1);
    step();
    en = 1'b0;
    chk("t3_count4", 64'(count), 64'd4);
    drain();

    // Lookup hit / cover / miss.
    st(27'h30, 32'h0000BEEF, 4'b0011);
    lkadr = 27'h30; lkbyteen = 4'b0001;
    #1;
    chk("t4_hit",  64'(lkhit),   64'd1);
    chk("t4_cov",  64'(lkcover), 64'd1);
    chk("t4_data", 64'(lkdata),  64'h0000BEEF);
    lkbyteen = 4'b1000;
    #1;
    chk("t4_hit2", 64'(lkhit),   64'd1);
    chk("t4_cov2", 64'(lkcover), 64'd0);
    lkadr = 27'h31;
    #1;
    chk("t4_miss", 64'(lkhit), 64'd0);
    step();
    drain();

    // Flush blocks stores while draining continues.
    st(27'h60, 32'h60, 4'b1111);
    st(27'h61, 32'h61, 4'b1111);
    st(27'h62, 32'h62, 4'b1111);
    flush = 1'b1; en = 1'b1; adr = 27'h63; data = 32'h63; byteen = 4'b1111;
    step();
    step();
    chk("t5_flush_done", 64'(done), 64'd0);
    memdone = 1'b1;
    repeat (3) step();
    memdone = 1'b0;
    chk("t5_empty", 64'(empty), 64'd1);
    flush = 1'b0;
    #1;
    chk("t5_done_back", 64'(done), 64'd1);
    step();
    en = 1'b0;
    drain();

    // Reset during an outstanding memory write discards everything.
    st(27'h70, 32'h70, 4'b1111);
    st(27'h71, 32'h71, 4'b1111);
    st(27'h72, 32'h72, 4'b1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_memen", 64'(memen), 64'd0);
    st(27'h7F, 32'h7F, 4'b1111);
    chk("t6_memadr", 64'(memadr), 64'h7F);
    drain();

    // Pointer wrap with overlapping enqueue and retire.
    for (int k = 0; k < DEPTH + 3; k++) begin
      en = 1'b1; adr = 27'h100 + 27'(k); data = $urandom; byteen = 4'b1111;
      memdone = (k > 0);
      step();
    end
    drain();

    // Randomised traffic over a small address set to provoke merges and hits.
    repeat (600) begin
      en       = 1'($urandom_range(0, 1));
      adr      = 27'h50 + 27'($urandom_range(0, 3));
      data     = $urandom;
      byteen   = 4'($urandom_range(0, 15));
      memdone  = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      lkadr    = 27'h50 + 27'($urandom_range(0, 3));
      lkbyteen = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wbuf_coalesce.md
Name: wbuf_coalesce

Overview:
Parametrised write buffer that supersedes the fixed 4-entry write buffer in memsys. It queues stores from the data cache in a circular FIFO of DEPTH entries and drains them to external memory in order. It adds three features: byte-lane write coalescing into the youngest entry, a read-forwarding lookup port so loads can see buffered stores, and a flush/drain mode. It sits between the data-side cache and memsyscontroller, which still arbitrates memory access.

Parameters:
DEPTH, 4, number of entries; power of 2, at least 2
AW, 27, word address width
DW, 32, data width; multiple of 8; byte lanes BE = DW/8 (derived localparam)
COALESCE, 1, 1 enables merging stores into the youngest entry; 0 gives a plain FIFO

Ports:
ph1  in  1  the single clock; all state updates on the rising edge of ph1
reset  in  1  synchronous, active-high
en  in  1  store request
adr  in  AW  store word address
data  in  DW  store data
byteen  in  BE  store byte enables
done  out  1  store accepted this cycle (handshake completes when en & done)
lkadr  in  AW  load lookup address
lkbyteen  in  BE  bytes the load needs
lkhit  out  1  some valid entry matches lkadr
lkcover  out  1  the matching entry's byteen covers lkbyteen
lkdata  out  DW  data of the youngest matching entry
memadr  out  AW  head entry address
memdata  out  DW  head entry data
membyteen  out  BE  head entry byte enables
memen  out  1  head entry is valid and requests memory
memdone  in  1  memory finished the current write
flush  in  1  drain request
empty  out  1  no valid entries
count  out  clog2(DEPTH)+1  number of valid entries

Behaviour:
- State: valid[DEPTH], entry{adr, data, byteen}[DEPTH], head pointer hd, tail pointer tl, count. Pointers wrap modulo DEPTH.
- Reset (synchronous): valid=0, hd=tl=0, count=0. After the reset edge: memen=0, empty=1, lkhit=0, lkcover=0. Reset in the middle of a memory write discards every entry; memen drops on the next edge regardless of memdone.
- Youngest entry y = tl-1.
- Coalescible (coal) = COALESCE & valid[y] & (y != hd) & (entry[y].adr == adr).
- done (combinational) = ~flush & (coal | count < DEPTH).
- Full buffer with memdone in the same cycle: done stays 0. done does not depend on memdone.
- Enqueue (en & done):
  - If coal: merge per byte lane. Lanes with byteen[i] take data lane i. entry[y].byteen |= byteen. Pointers and count unchanged.
  - Otherwise: write entry[tl], set valid[tl]=1, tl++, count++.
- The head entry is never modified. memadr, memdata and membyteen stay stable while memen & ~memdone.
- Drain:
  - memen = valid[hd]. Memory outputs come combinationally from entry[hd].
  - On memen & memdone: clear valid[hd], hd++, count--. There is one edge of latency, so the next entry is presented the cycle after memdone.
- Simultaneous enqueue (non-coalescing) and retire: count unchanged, both pointers advance.
- Simultaneous coalesce into y and retire of hd is legal, because y != hd.
- Retire of the last entry together with enqueue: empty stays 0.
- Lookup is purely combinational:
  - Compare lkadr against all valid entries; the youngest match, scanning from tl-1 back to hd, wins.
  - lkdata = that entry's data.
  - lkcover = lkhit & ((entry.byteen & lkbyteen) == lkbyteen).
  - lkhit & ~lkcover means the consumer must stall until the buffer drains. Older duplicate entries are not merged.
  - The lookup reflects state before any same-cycle enqueue.
- flush: while asserted, done=0 and draining continues. empty = (count == 0). Deasserting flush restores done the same cycle.
- memdone with memen=0 is ignored.

Decomposition:
- Shared package: no typedefs required.
- Sub-module wbuf_match: parametrised priority match over DEPTH entries, ordered by hd. Outputs a one-hot youngest-match select plus a hit flag; the one-hot select drives an and-or mux for lkdata.
- Pointer increment reuses the existing inc cell. Byte-merge logic stays inline.

Test Plan:
- Reset, then en, adr=0x10, byteen=4'b1111, data=0xAABBCCDD → done=1. Next cycle: count=1, memen=1, memadr=0x10, memdata=0xAABBCCDD. memdone=1 → the next cycle shows empty=1, memen=0.
- Hold memdone=0 and store 0x10/4'b1111, then 0x20/4'b0001 data 0x11, then 0x20/4'b0100 data 0x00330000 → count=2. Entry 0x20 has byteen 4'b0101 and data 0x..33..11. memadr stays 0x10 throughout.
- Hold memdone=0 and store to 0x10 twice → count=2, because the head is never coalesced. Then store to five distinct addresses (DEPTH=4) → done=0 once count=4. Assert memdone with en held → acceptance occurs on the cycle after the retire.
- Buffer holds 0x30/4'b0011 → lkadr=0x30, lkbyteen=4'b0001 gives lkhit=1, lkcover=1. lkbyteen=4'b1000 gives lkhit=1, lkcover=0. lkadr=0x31 gives lkhit=0.
- Fill three entries, assert flush with en=1 → done=0 every cycle. Pulse memdone three times → empty=1, then deassert flush → done=1.
- Issue reset while memen=1 and memdone=0 with three entries queued → after the edge: count=0, memen=0, hd=tl=0. Pointer wrap check: enqueue and retire DEPTH+3 entries in sequence → ordering preserved.
